// File: rtl/game_beam_gen_if.sv
// Beam bus between game_beam_gen and its consumers: clock enable in, VGA pins and
// game-space beam signals out.
interface game_beam_gen_if #(
  parameter int unsigned SX_W = 8,
  parameter int unsigned SY_W = 9
);
  logic            ce;
  logic            hsync;
  logic            vsync;
  logic            vga_de;
  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic            game_pix_stb;
  logic            frame_stb;
  logic            display_enabled;

  modport master (
    input  ce,
    output hsync, vsync, vga_de, sx, sy, game_pix_stb, frame_stb, display_enabled
  );

  modport slave (
    output ce,
    input  hsync, vsync, vga_de, sx, sy, game_pix_stb, frame_stb, display_enabled
  );
endinterface

// File: rtl/game_beam_gen.sv
// VGA raster generator that also maps an upscaled GAME_W x GAME_H window onto the raster and
// emits game-space beam coordinates and strobes. All outputs are registered (1 clock latency).
module game_beam_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned GAME_W   = 224,
  parameter int unsigned GAME_H   = 288,
  parameter int unsigned SCALE    = 1,
  parameter int unsigned H_OFF    = 208,
  parameter int unsigned V_OFF    = 96
) (
  input logic             vga_pix_clk,
  input logic             rst,
  game_beam_gen_if.master beam
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned SX_W    = $clog2(GAME_W);
  localparam int unsigned SY_W    = $clog2(GAME_H);
  localparam int unsigned SUB_W   = 2;

  // Inclusive bounds keep every constant representable in the counter width.
  localparam logic [HC_W-1:0] HC_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_LAST  = HC_W'(H_ACTIVE - 1);
  localparam logic [HC_W-1:0] H_SYNC_LO   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] H_SYNC_LAST = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HC_W-1:0] H_WIN_LO    = HC_W'(H_OFF);
  localparam logic [HC_W-1:0] H_WIN_LAST  = HC_W'(H_OFF + GAME_W * SCALE - 1);
  localparam logic [VC_W-1:0] VC_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_LAST  = VC_W'(V_ACTIVE - 1);
  localparam logic [VC_W-1:0] V_SYNC_LO   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] V_SYNC_LAST = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VC_W-1:0] V_WIN_LO    = VC_W'(V_OFF);
  localparam logic [VC_W-1:0] V_WIN_LAST  = VC_W'(V_OFF + GAME_H * SCALE - 1);
  localparam logic [SX_W-1:0] GX_LAST     = SX_W'(GAME_W - 1);
  localparam logic [SY_W-1:0] GY_LAST     = SY_W'(GAME_H - 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SCALE - 1);

  if (H_OFF + GAME_W * SCALE > H_ACTIVE) begin : g_chk_h
    $fatal(1, "game_beam_gen: game window exceeds horizontal active area");
  end
  if (V_OFF + GAME_H * SCALE > V_ACTIVE) begin : g_chk_v
    $fatal(1, "game_beam_gen: game window exceeds vertical active area");
  end
  if (SCALE < 1 || SCALE > 4) begin : g_chk_scale
    $fatal(1, "game_beam_gen: SCALE must be in 1..4");
  end

  logic [HC_W-1:0]  r_hc,   w_hc_d;
  logic [VC_W-1:0]  r_vc,   w_vc_d;
  logic [SUB_W-1:0] r_hsub, w_hsub_d;
  logic [SUB_W-1:0] r_vsub, w_vsub_d;
  logic [SX_W-1:0]  r_gx,   w_gx_d;
  logic [SY_W-1:0]  r_gy,   w_gy_d;

  logic            r_hsync;
  logic            r_vsync;
  logic            r_vga_de;
  logic [SX_W-1:0] r_sx;
  logic [SY_W-1:0] r_sy;
  logic            r_game_pix_stb;
  logic            r_frame_stb;
  logic            r_display_enabled;

  logic w_h_win;
  logic w_v_win;
  logic w_in_win;
  logic w_line_end;
  logic w_frame_end;
  logic w_hsync_act;
  logic w_vsync_act;
  logic w_de;

  always_comb begin
    w_h_win     = (r_hc >= H_WIN_LO) && (r_hc <= H_WIN_LAST);
    w_v_win     = (r_vc >= V_WIN_LO) && (r_vc <= V_WIN_LAST);
    w_in_win    = w_h_win && w_v_win;
    w_line_end  = (r_hc == HC_LAST);
    w_frame_end = w_line_end && (r_vc == VC_LAST);
    w_hsync_act = (r_hc >= H_SYNC_LO) && (r_hc <= H_SYNC_LAST);
    w_vsync_act = (r_vc >= V_SYNC_LO) && (r_vc <= V_SYNC_LAST);
    w_de        = (r_hc <= H_ACT_LAST) && (r_vc <= V_ACT_LAST);
  end

  // Raster and game-pixel counter next state; only committed on ce=1 cycles.
  always_comb begin
    w_hc_d   = r_hc + HC_W'(1);
    w_vc_d   = r_vc;
    w_hsub_d = r_hsub;
    w_vsub_d = r_vsub;
    w_gx_d   = r_gx;
    w_gy_d   = r_gy;

    if (w_in_win) begin
      if (r_hsub == SUB_LAST) begin
        w_hsub_d = '0;
        // Saturate so gx never leaves 0..GAME_W-1 after the last game pixel.
        if (r_gx != GX_LAST) begin
          w_gx_d = r_gx + SX_W'(1);
        end
      end else begin
        w_hsub_d = r_hsub + SUB_W'(1);
      end
    end

    if (w_line_end) begin
      w_hc_d   = '0;
      w_hsub_d = '0;
      w_gx_d   = '0;
      if (w_frame_end) begin
        w_vc_d   = '0;
        w_vsub_d = '0;
        w_gy_d   = '0;
      end else begin
        w_vc_d = r_vc + VC_W'(1);
        if (w_v_win) begin
          if (r_vsub == SUB_LAST) begin
            w_vsub_d = '0;
            if (r_gy != GY_LAST) begin
              w_gy_d = r_gy + SY_W'(1);
            end
          end else begin
            w_vsub_d = r_vsub + SUB_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      r_hc              <= '0;
      r_vc              <= '0;
      r_hsub            <= '0;
      r_vsub            <= '0;
      r_gx              <= '0;
      r_gy              <= '0;
      r_hsync           <= ~SYNC_POL;
      r_vsync           <= ~SYNC_POL;
      r_vga_de          <= 1'b0;
      r_sx              <= '0;
      r_sy              <= '0;
      r_game_pix_stb    <= 1'b0;
      r_frame_stb       <= 1'b0;
      r_display_enabled <= 1'b0;
    end else if (beam.ce) begin
      r_hc              <= w_hc_d;
      r_vc              <= w_vc_d;
      r_hsub            <= w_hsub_d;
      r_vsub            <= w_vsub_d;
      r_gx              <= w_gx_d;
      r_gy              <= w_gy_d;
      r_hsync           <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
      r_vsync           <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
      r_vga_de          <= w_de;
      r_sx              <= w_in_win ? r_gx : '0;
      r_sy              <= w_in_win ? r_gy : '0;
      r_game_pix_stb    <= w_in_win && (r_hsub == '0) && (r_vsub == '0);
      r_frame_stb       <= (r_hc == H_WIN_LO) && (r_vc == V_WIN_LO);
      r_display_enabled <= w_in_win;
    end else begin
      // Strobes must not repeat while the raster is stalled; levels hold.
      r_game_pix_stb <= 1'b0;
      r_frame_stb    <= 1'b0;
    end
  end

  assign beam.hsync           = r_hsync;
  assign beam.vsync           = r_vsync;
  assign beam.vga_de          = r_vga_de;
  assign beam.sx              = r_sx;
  assign beam.sy              = r_sy;
  assign beam.game_pix_stb    = r_game_pix_stb;
  assign beam.frame_stb       = r_frame_stb;
  assign beam.display_enabled = r_display_enabled;

endmodule
